// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame buffer: stores GRB bytes from the SPI side, replays them to the bit encoder, then holds the latch gap.
// Optional: define WS2812_AUTO_START_EN so that filling the buffer starts transmission without a frame_start pulse.
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int RESET_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       frame_start,
  output logic [7:0] enc_byte,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int FRAME_BYTES = NUM_LEDS * 3;
  // FRAME_BYTES is never a power of two, so this width also exactly indexes the memory.
  localparam int PTR_W = $clog2(FRAME_BYTES + 1);
  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] latch_cnt;
  logic [7:0]       mem [FRAME_BYTES];

  logic wr_en, manual_start, auto_start, start_req;
  logic xfer, last_xfer, latch_done;

  assign in_ready  = (state == IDLE) && (wr_ptr < FULL);
  assign wr_en     = in_valid && in_ready;
  assign enc_valid = (state == SEND);
  assign enc_byte  = enc_valid ? mem[rd_ptr] : 8'h00;
  assign busy      = (state != IDLE);

  assign xfer       = enc_valid && enc_ready;
  assign last_xfer  = xfer && (rd_ptr == wr_ptr - PTR_W'(1));
  assign latch_done = (latch_cnt == CNT_W'(RESET_CYCLES - 1));

  // A same-cycle write counts as data present, so a lone byte plus frame_start is a valid frame.
  assign manual_start = (state == IDLE) && frame_start && ((wr_ptr != '0) || wr_en);

`ifdef WS2812_AUTO_START_EN
  assign auto_start = wr_en && (wr_ptr == FULL - PTR_W'(1));
`else
  assign auto_start = 1'b0;
`endif

  assign start_req = manual_start || auto_start;

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req)  state_next = SEND;
      SEND:    if (last_xfer)  state_next = LATCH;
      LATCH:   if (latch_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      latch_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;

      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (xfer)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (state == LATCH) begin
        if (latch_done) begin
          latch_cnt <= '0;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
        end else begin
          latch_cnt <= latch_cnt + CNT_W'(1);
        end
      end

      // Clearing on an accepted start wins: that frame drains the full buffer.
      if (manual_start)
        overflow <= 1'b0;
      else if ((state == IDLE) && in_valid && (wr_ptr == FULL))
        overflow <= 1'b1;
    end
  end

  // NOTE: the frame memory is left unreset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: vector table for the basic frame, scripted corner sequences, byte scoreboard.
module tb_ws2812_frame_ctrl;

  localparam int NL = 8;
  localparam int RC = 16;
  localparam int FB = NL * 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       enc_ready = 1'b0;
  logic       in_ready, enc_valid, busy, overflow;
  logic [7:0] enc_byte;

  ws2812_frame_ctrl #(.NUM_LEDS(NL), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .frame_start(frame_start),
    .enc_byte(enc_byte), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit push);
    in_valid = 1'b1;
    in_data  = d;
    if (push) exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    enc_ready = 1'b1;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Scoreboard: every accepted encoder byte must match the next expected byte; stalled bytes must hold.
  logic       stall_d = 1'b0;
  logic [7:0] byte_d = 8'h00;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_d && enc_valid) check("stall_hold", enc_byte, byte_d);
      if (enc_valid && enc_ready) begin
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("sb_byte", enc_byte, exp_b);
        end
      end
    end
    stall_d <= rst_n && enc_valid && !enc_ready;
    byte_d  <= enc_byte;
  end

  typedef struct {
    int iv; int d; int fs; int er; int push;
    int rdy; int bsy; int ev; int eb; int ovf;
  } vec_t;

  vec_t vecs[10];
  bit   pat[4];
  int   n;

  initial begin
    vecs[0] = '{0, 0,     0, 0, 0,  1, 0, 0, 0,     0};
    vecs[1] = '{0, 0,     1, 0, 0,  1, 0, 0, 0,     0};
    vecs[2] = '{0, 0,     0, 0, 0,  1, 0, 0, 0,     0};
    vecs[3] = '{1, 'h11,  0, 0, 1,  1, 0, 0, 0,     0};
    vecs[4] = '{1, 'h22,  0, 0, 1,  1, 0, 0, 0,     0};
    vecs[5] = '{1, 'h33,  0, 0, 1,  1, 0, 0, 0,     0};
    vecs[6] = '{0, 0,     1, 1, 0,  0, 1, 1, 'h11,  0};
    vecs[7] = '{0, 0,     0, 1, 0,  0, 1, 1, 'h22,  0};
    vecs[8] = '{0, 0,     0, 1, 0,  0, 1, 1, 'h33,  0};
    vecs[9] = '{0, 0,     0, 1, 0,  0, 1, 0, 0,     0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_enc_valid", enc_valid, 0);
    check("rst_enc_byte", enc_byte, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);

    // Empty frame_start ignored, then a 3-byte frame at full rate
    for (int i = 0; i < 10; i++) begin
      in_valid    = (vecs[i].iv != 0);
      in_data     = 8'(vecs[i].d);
      frame_start = (vecs[i].fs != 0);
      enc_ready   = (vecs[i].er != 0);
      if (vecs[i].push != 0) exp_q.push_back(8'(vecs[i].d));
      step();
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("vec%0d_enc_valid", i), enc_valid, vecs[i].ev);
      check($sformatf("vec%0d_enc_byte", i), enc_byte, vecs[i].eb);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
    end
    in_valid = 1'b0;
    frame_start = 1'b0;

    // Latch gap length; frame_start and a byte offered mid-gap must be ignored
    n = 1;
    for (int k = 0; k < RC + 10; k++) begin
      if (k == 3) begin
        check("latch_in_ready", in_ready, 0);
        frame_start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hEE;
      end else begin
        frame_start = 1'b0;
        in_valid = 1'b0;
      end
      step();
      if (k == 3) check("latch_no_overflow", overflow, 0);
      if (!busy) break;
      n++;
    end
    frame_start = 1'b0;
    in_valid = 1'b0;
    check("latch_len", n, RC);
    check("post_latch_in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("no_second_frame_ev", enc_valid, 0);
      check("no_second_frame_busy", busy, 0);
    end

    // Backpressure 1-0-0-1
    for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i), 1'b1);
    enc_ready = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("stall_first_ev", enc_valid, 1);
    check("stall_first_byte", enc_byte, 8'hA1);
    for (int k = 0; k < 40; k++) begin
      if (!enc_valid) break;
      enc_ready = pat[k % 4];
      step();
    end
    check("stall_all_sent", exp_q.size(), 0);
    wait_idle();

`ifndef WS2812_AUTO_START_EN
    // Full buffer, overflow, then flush
    for (int i = 0; i < FB; i++) wr(8'(i * 7 + 3), 1'b1);
    check("full_in_ready", in_ready, 0);
    wr(8'hFF, 1'b0);
    check("ovf_set", overflow, 1);
    step();
    check("ovf_sticky", overflow, 1);
    enc_ready = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("ovf_clear", overflow, 0);
    check("full_send_ev", enc_valid, 1);
    wait_idle();
    check("full_frame_sent", exp_q.size(), 0);
`endif

    // Reset during SEND while byte index 2 is presented
    wr(8'h55, 1'b1);
    wr(8'h66, 1'b1);
    wr(8'h77, 1'b1);
    enc_ready = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    check("pre_reset_byte", enc_byte, 8'h77);
    rst_n = 1'b0;
    enc_ready = 1'b0;
    step();
    check("rst_abort_ev", enc_valid, 0);
    check("rst_abort_busy", busy, 0);
    check("rst_abort_in_ready", in_ready, 1);
    exp_q.delete();
    rst_n = 1'b1;
    step();
    wr(8'h99, 1'b1);
    enc_ready = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("restart_ev", enc_valid, 1);
    check("restart_mem0", enc_byte, 8'h99);
    step();
    check("restart_one_byte", enc_valid, 0);
    wait_idle();

    // Filling the buffer without frame_start
    for (int i = 0; i < FB; i++) wr(8'hC0 + 8'(i), 1'b1);
`ifdef WS2812_AUTO_START_EN
    check("auto_start_ev", enc_valid, 1);
    check("auto_start_byte", enc_byte, 8'hC0);
`else
    check("full_idle_ev", enc_valid, 0);
    step();
    step();
    check("full_waits_busy", busy, 0);
    check("full_waits_ready", in_ready, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("manual_start_ev", enc_valid, 1);
`endif
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_ctrl.md
WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of RGB LEDs buffered (frame capacity NUM_LEDS*3 bytes).
REQ-002 SHALL have parameter RESET_CYCLES, default 1000, WS2812 latch/reset gap length in clk cycles (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_data  input  8  byte from SPI receiver (GRB order, MSB-first as sent).
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  buffer accepts a byte this cycle.
REQ-008 SHALL have port frame_start  input  1  request to transmit the buffered frame.
REQ-009 SHALL have port enc_byte  output  8  byte to WS2812 bit encoder.
REQ-010 SHALL have port enc_valid  output  1  enc_byte valid.
REQ-011 SHALL have port enc_ready  input  1  encoder accepts enc_byte.
REQ-012 SHALL have port busy  output  1  frame transmission or latch gap in progress.
REQ-013 SHALL have port overflow  output  1  sticky: byte offered while buffer full.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, LATCH; reset state IDLE.
REQ-015 in_ready SHALL be high iff state==IDLE and wr_ptr < NUM_LEDS*3 (combinational).
REQ-016 Byte write SHALL occur when in_valid&in_ready: mem[wr_ptr]<=in_data, wr_ptr+1.
REQ-017 In IDLE, frame_start with wr_ptr==0 and no same-cycle write SHALL be ignored.
REQ-018 In IDLE, frame_start with data present SHALL go to SEND next cycle; frame length = wr_ptr including any same-cycle write.
REQ-019 frame_start in SEND or LATCH SHALL be ignored (not queued).
REQ-020 In SEND, enc_valid SHALL be high and enc_byte=mem[rd_ptr], rd_ptr starting at 0; first enc_valid exactly 1 cycle after accepted frame_start.
REQ-021 Transfer SHALL occur on enc_valid&enc_ready; rd_ptr+1; enc_byte SHALL remain stable while enc_valid&!enc_ready.
REQ-022 On transfer of byte index length-1, SHALL enter LATCH next cycle with enc_valid low.
REQ-023 LATCH SHALL last exactly RESET_CYCLES cycles, then IDLE with wr_ptr=0, rd_ptr=0.
REQ-024 busy SHALL be high exactly in SEND and LATCH.
REQ-025 overflow SHALL set when in_valid high in IDLE with wr_ptr==NUM_LEDS*3; cleared only by reset or accepted frame_start.
REQ-026 Bytes offered while in_ready low in SEND/LATCH SHALL not be written and SHALL not set overflow.
REQ-027 Buffer contents SHALL persist after a frame; only pointers clear.

Reset
REQ-028 rst_n low at a clk edge SHALL force IDLE, wr_ptr=0, rd_ptr=0, latch counter=0, overflow=0, enc_valid=0, enc_byte=0, busy=0; in_ready=1 after release.
REQ-029 Reset mid-SEND/LATCH SHALL abort immediately; enc_valid low on the following cycle; no partial-frame resumption.
REQ-030 Buffer memory SHALL NOT require reset.

Configuration
REQ-031 Macro WS2812_AUTO_START_EN defined: in IDLE, the write filling the buffer (wr_ptr reaching NUM_LEDS*3) SHALL start SEND next cycle as an implicit frame_start.
REQ-032 Macro WS2812_AUTO_START_EN undefined: SEND SHALL start only via frame_start; full buffer waits in IDLE.

Verification
REQ-033 Write 3 bytes 0x11,0x22,0x33, pulse frame_start, enc_ready=1 -> enc_byte 0x11,0x22,0x33 on 3 consecutive cycles, then enc_valid low, busy high exactly RESET_CYCLES more cycles, then in_ready=1.
REQ-034 SEND with enc_ready toggling 1-0-0-1 -> each byte held stable while stalled, no byte skipped or duplicated.
REQ-035 Fill 24 bytes (NUM_LEDS=8), then one more in_valid -> in_ready=0, overflow=1; frame_start -> overflow=0, 24 bytes sent.
REQ-036 frame_start with empty buffer -> busy stays 0, enc_valid stays 0; frame_start during LATCH -> no second frame.
REQ-037 rst_n low during SEND at byte 2 -> next cycle enc_valid=0, busy=0, in_ready=1; new 1-byte frame sends from mem[0].
REQ-038 With WS2812_AUTO_START_EN, 24th write -> enc_valid high 1 cycle later without frame_start; without macro, stays IDLE.
